h14tx_decoding_terc4: RTL
=========================

Name: h14tx_decoding_terc4

Overview:
TERC4 symbol decoder and data-island framer for HDMI 1.4 TMDS channels 1/2, the inverse of the TERC4 encoder. It consumes one 10-bit TMDS symbol per pixel-clock enable and classifies it as control token, data-island guard band, TERC4 or invalid. It recovers the 4-bit nibble and tracks data-island framing (leading guard, 32-symbol packets, trailing guard). It is used as the TX loopback/self-check path and as the RX-side channel front end.

Parameters:
MAX_PACKETS, 18, maximum packets per data island; the limit is inclusive and must be at least 1
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk_i  input  1  pixel clock
rst_ni  input  1  asynchronous active-low reset
sym_valid_i  input  1  symbol_i is valid this cycle
symbol_i  input  symbol_t  TMDS symbol, bit 0 first on the wire
err_clr_i  input  1  synchronous clear of err_cnt_o
data_valid_o  output  1  data_o holds an island payload nibble
data_o  output  data_t  decoded TERC4 nibble
sop_o  output  1  first nibble of a 32-symbol packet
island_o  output  1  framer is in an island state
ctrl_valid_o  output  1  control token decoded
ctrl_o  output  2  {CTL1,CTL0} or {CTL3,CTL2} of the token
guard_o  output  1  data-island guard symbol 0100110011 received
island_end_o  output  1  one-cycle pulse when the trailing guard completes
sym_err_o  output  1  symbol matches no table (TERC4, control, guard)
frame_err_o  output  1  framing violation; the framer returns to CTRL
err_cnt_o  output  ERR_CNT_W  saturating count of sym_err_o and frame_err_o events

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low: clk_i and rst_ni.
- Reset values: all outputs are 0, the state is CTRL, and the counters are 0.
- Latency: every output is registered. Output pulses appear exactly one cycle after the sym_valid_i cycle that caused them. Without sym_valid_i, all pulse outputs drop to 0. err_cnt_o, island_o and the state hold.
- Classification priority: guard > control > TERC4 > invalid. The guard pattern is distinct from all 16 TERC4 codes and all 4 control codes.
- Guard symbol: data_o = 0.
- Invalid symbol: data_o = 0.
- Control tokens:
  - 1101010100 gives 00
  - 0010101011 gives 01
  - 0101010100 gives 10
  - 1010101011 gives 11
- Framer states: CTRL, LGB, ISLAND, TGB.
- Counters: sym_cnt is 5 bits and wraps 31 to 0. pkt_cnt has width clog2(MAX_PACKETS+1).
- CTRL state:
  - guard: go to LGB.
  - anything else: stay in CTRL, no error.
- LGB state:
  - guard: go to ISLAND and clear sym_cnt and pkt_cnt.
  - anything else: assert frame_err_o and go to CTRL.
- ISLAND state, handled at a packet boundary (sym_cnt == 0):
  - If pkt_cnt ≥ 1 and the symbol is guard: go to TGB. This symbol is not data.
  - If pkt_cnt == MAX_PACKETS and the symbol is not guard: assert frame_err_o and go to CTRL.
- ISLAND state, TERC4 symbol: data_valid_o = 1 and data_o = the decoded nibble. sop_o = 1 when sym_cnt == 0. sym_cnt increments. When sym_cnt wraps 31 to 0, pkt_cnt increments.
- ISLAND state, invalid symbol:
  - sym_err_o = 1, data_valid_o = 1, data_o = 0.
  - The counter advances and the state is kept, because bit errors must not lose alignment.
- ISLAND state, control token or mid-packet guard: assert frame_err_o, go to CTRL, and do not assert data_valid_o.
- TGB state:
  - guard: assert island_end_o and go to CTRL.
  - anything else: assert frame_err_o and go to CTRL.
- island_o: 1 in LGB, ISLAND and TGB, registered with the state.
- Simultaneous sym_err and frame_err: the error counter increments by 1 per symbol.
- err_clr_i together with an error: the clear wins and the counter becomes 0.
- Saturation: err_cnt_o saturates at all-ones.
- Reset mid-island: the state returns to CTRL immediately. There is no island_end_o pulse.

Decomposition:
- h14tx_pkg gets the following:
  - TERC4 code constants, indexed by nibble.
  - The control token constants.
  - DI_GUARD = 10'b0100110011.
  - A ctrl_t typedef (2 bits).
  - A framer state enum, terc4_fsm_e.
- Sub-module h14tx_decoding_terc4_lut: a combinational map from symbol to {is_guard, is_ctrl, ctrl, is_terc4, data}. It is reusable by the channel 0 decoder.

Test Plan:
- Table sweep: drive all 16 TERC4 codes in CTRL, then in ISLAND. Expect data_o to equal each index 0..15. sym_err_o stays 0 throughout. data_valid_o is 1 only in ISLAND, one cycle later.
- One-packet island: send guard, guard, 32 TERC4 symbols (nibble i%16), guard, guard. Expect the following:
  - island_o is 1.
  - sop_o fires once, on the first nibble.
  - 32 data_valid_o pulses.
  - island_end_o fires one cycle after the last guard.
  - frame_err_o stays 0.
- Framing errors, checked separately:
  - guard followed by control token 00: expect frame_err_o and state CTRL.
  - control token 01 at packet symbol 10: expect frame_err_o, and no data_valid_o for that symbol.
  - 19 packets with MAX_PACKETS=18: frame_err_o fires at symbol 0 of packet 19.
- Invalid symbol 10'h3FF at packet symbol 5: expect sym_err_o=1 and data_o=0. Alignment is kept, so the next sop_o still comes 27 symbols later. err_cnt_o becomes 1.
- Reset mid-island: assert rst_ni=0 at packet symbol 15. Outputs clear asynchronously. After release, the next guard pair starts a fresh island with sop_o on its first nibble.
- Counter: set ERR_CNT_W=2 and inject 5 invalid symbols. Expect err_cnt_o to saturate at 3. Assert err_clr_i with a simultaneous error and expect err_cnt_o=0.

Source files
------------

// File: rtl/h14tx_pkg.sv
// ============================================================================
// Module : h14tx_pkg
// Brief  : Shared TMDS/TERC4 types, code tables and framer state encoding
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package h14tx_pkg;

  typedef logic [9:0] symbol_t;
  typedef logic [3:0] data_t;
  typedef logic [1:0] ctrl_t;

  // Data-island framer states
  typedef enum logic [1:0] {
    ST_CTRL   = 2'd0,
    ST_LGB    = 2'd1,
    ST_ISLAND = 2'd2,
    ST_TGB    = 2'd3
  } terc4_fsm_e;

  // Data-island guard band symbol for channels 1 and 2
  localparam symbol_t DI_GUARD = 10'b0100110011;

  // TERC4 code words, indexed by the nibble they carry
  localparam symbol_t TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  // Control tokens, indexed by the {CTLn+1,CTLn} pair they carry
  localparam symbol_t CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

endpackage : h14tx_pkg

`default_nettype wire

// File: rtl/h14tx_decoding_terc4_lut.sv
// ============================================================================
// Module : h14tx_decoding_terc4_lut
// Brief  : Combinational symbol classifier (guard > control > TERC4)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module h14tx_decoding_terc4_lut
  import h14tx_pkg::*;
(
  input  symbol_t symbol,
  output logic    is_guard,
  output logic    is_ctrl,
  output ctrl_t   ctrl,
  output logic    is_terc4,
  output data_t   data
);

  // Table search in priority order; data/ctrl stay 0 when not matched
  always_comb begin
    is_guard = (symbol == DI_GUARD);
    is_ctrl  = 1'b0;
    ctrl     = '0;
    is_terc4 = 1'b0;
    data     = '0;
    if (symbol != DI_GUARD) begin
      for (int i = 0; i < 4; i++) begin
        if (symbol == CTRL_CODE[i]) begin
          is_ctrl = 1'b1;
          ctrl    = ctrl_t'(i);
        end
      end
      if (!is_ctrl) begin
        for (int i = 0; i < 16; i++) begin
          if (symbol == TERC4_CODE[i]) begin
            is_terc4 = 1'b1;
            data     = data_t'(i);
          end
        end
      end
    end
  end

endmodule : h14tx_decoding_terc4_lut

`default_nettype wire

// File: rtl/h14tx_decoding_terc4.sv
// ============================================================================
// Module : h14tx_decoding_terc4
// Brief  : TERC4 decoder and data-island framer for TMDS channels 1/2
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module h14tx_decoding_terc4
  import h14tx_pkg::*;
#(
  parameter int MAX_PACKETS = 18,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sym_valid_i,
  input  symbol_t              symbol_i,
  input  logic                 err_clr_i,
  output logic                 data_valid_o,
  output data_t                data_o,
  output logic                 sop_o,
  output logic                 island_o,
  output logic                 ctrl_valid_o,
  output logic [1:0]           ctrl_o,
  output logic                 guard_o,
  output logic                 island_end_o,
  output logic                 sym_err_o,
  output logic                 frame_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int PKT_W = $clog2(MAX_PACKETS + 1);

  logic       is_guard, is_ctrl, is_terc4;
  ctrl_t      ctrl;
  data_t      nibble;

  terc4_fsm_e       state;
  logic [4:0]       sym_cnt;
  logic [PKT_W-1:0] pkt_cnt;

  logic at_boundary, pkt_full, invalid, fr_err, payload, go_tgb, end_island, err_event;

  h14tx_decoding_terc4_lut u_lut (
    .symbol   (symbol_i),
    .is_guard (is_guard),
    .is_ctrl  (is_ctrl),
    .ctrl     (ctrl),
    .is_terc4 (is_terc4),
    .data     (nibble)
  );

  // Framing decision for the current symbol in the current state
  always_comb begin
    at_boundary = (sym_cnt == 5'd0);
    pkt_full    = (pkt_cnt == PKT_W'(MAX_PACKETS));
    invalid     = !is_guard && !is_ctrl && !is_terc4;
    fr_err      = 1'b0;
    payload     = 1'b0;
    go_tgb      = 1'b0;
    end_island  = 1'b0;
    unique case (state)
      ST_CTRL:   ;
      ST_LGB:    fr_err = !is_guard;
      ST_ISLAND: begin
        // A guard only closes the island after at least one whole packet;
        // invalid symbols are still counted so alignment survives bit errors
        if (at_boundary && (pkt_cnt != '0) && is_guard) go_tgb = 1'b1;
        else if (at_boundary && pkt_full)               fr_err = 1'b1;
        else if (is_guard || is_ctrl)                   fr_err = 1'b1;
        else                                            payload = 1'b1;
      end
      ST_TGB: begin
        if (is_guard) end_island = 1'b1;
        else          fr_err     = 1'b1;
      end
      default: ;
    endcase
    err_event = sym_valid_i && (invalid || fr_err);
  end

  // Framer state, packet counters and registered symbol outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_CTRL;
      sym_cnt      <= '0;
      pkt_cnt      <= '0;
      island_o     <= 1'b0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      sop_o        <= 1'b0;
      ctrl_valid_o <= 1'b0;
      ctrl_o       <= '0;
      guard_o      <= 1'b0;
      island_end_o <= 1'b0;
      sym_err_o    <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      ctrl_valid_o <= 1'b0;
      guard_o      <= 1'b0;
      island_end_o <= 1'b0;
      sym_err_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      if (sym_valid_i) begin
        data_o       <= is_terc4 ? nibble : '0;
        ctrl_o       <= is_ctrl ? ctrl : '0;
        ctrl_valid_o <= is_ctrl;
        guard_o      <= is_guard;
        sym_err_o    <= invalid;
        frame_err_o  <= fr_err;
        island_end_o <= end_island;
        data_valid_o <= payload;
        sop_o        <= payload && at_boundary;
        if (payload) begin
          sym_cnt <= sym_cnt + 5'd1;
          if (sym_cnt == 5'd31) pkt_cnt <= pkt_cnt + PKT_W'(1);
        end
        if (fr_err || end_island) begin
          state    <= ST_CTRL;
          island_o <= 1'b0;
        end else if (go_tgb) begin
          state <= ST_TGB;
        end else if (state == ST_CTRL && is_guard) begin
          state    <= ST_LGB;
          island_o <= 1'b1;
        end else if (state == ST_LGB) begin
          state   <= ST_ISLAND;
          sym_cnt <= '0;
          pkt_cnt <= '0;
        end
      end
    end
  end

  // Saturating error counter; a clear overrides a simultaneous error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_cnt_o <= '0;
    end else if (err_event && !(&err_cnt_o)) begin
      err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

endmodule : h14tx_decoding_terc4

`default_nettype wire
